// File: rtl/mxn_pkg.sv
// Shared helpers and derived widths for the two-lane deskew buffer.
package mxn_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Widths for the default configuration (M=3, N=4, DEPTH=16).
  localparam int unsigned DEF_M     = 3;
  localparam int unsigned DEF_N     = 4;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned LVL_W     = clog2(DEF_DEPTH + 1);
  localparam int unsigned INF_W     = clog2(2 * DEF_N + 1);
  localparam int unsigned PAIR_W    = 2 * DEF_M;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; full/empty derive from the level counter.
module sync_fifo
  import mxn_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [clog2(DEPTH+1)-1:0]    level
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned LW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/mxn_deskew_buffer.sv
// Realigns the N-deep and 2N-deep pipeline lanes into pairs and issues launch credit.
module mxn_deskew_buffer
  import mxn_pkg::*;
#(
  parameter int unsigned M     = 3,
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          launch,
  input  logic [M-1:0]                  lane0,
  input  logic [M-1:0]                  lane1,
  output logic                          can_launch,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*M-1:0]                out_data,
  output logic [clog2(DEPTH+1)-1:0]     level,
  output logic                          err
);

  localparam int unsigned InfW = clog2(2 * N + 1);
  localparam int unsigned LvlW = clog2(DEPTH + 1);
  localparam int unsigned Q0W  = clog2(N + 1);

  logic [2*N-1:0]  vsr_q, vsr_d;
  logic [InfW-1:0] inflight_q, inflight_d;
  logic            err_q, err_d;
  logic            vn, v2n, pair_push, pop;
  logic [M-1:0]    q0_head;
  logic            q0_full, q0_empty;
  logic [Q0W-1:0]  q0_level;
  logic            of_full, of_empty;
  logic [LvlW-1:0] of_level;
  logic [31:0]     credit_sum;
  logic            q0_unused;

  // Tap k-1 of the shift register is high k cycles after the launch.
  assign vn        = vsr_q[N-1];
  assign v2n       = vsr_q[2*N-1];
  assign pair_push = v2n && !q0_empty;
  assign pop       = out_valid && out_ready;
  assign q0_unused = ^{q0_level, q0_full};

  sync_fifo #(
    .WIDTH (M),
    .DEPTH (N)
  ) u_lane0_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vn),
    .wdata (lane0),
    .pop   (v2n),
    .rdata (q0_head),
    .full  (q0_full),
    .empty (q0_empty),
    .level (q0_level)
  );

  sync_fifo #(
    .WIDTH (2 * M),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pair_push),
    .wdata ({lane1, q0_head}),
    .pop   (pop),
    .rdata (out_data),
    .full  (of_full),
    .empty (of_empty),
    .level (of_level)
  );

  assign out_valid  = !of_empty;
  assign level      = of_level;
  // Registered values only, so credit freed by a pop shows up one cycle later.
  assign credit_sum = 32'(inflight_q) + 32'(of_level);
  assign can_launch = (credit_sum < DEPTH);
  assign err        = err_q;

  always_comb begin
    vsr_d      = {vsr_q[2*N-2:0], launch};
    inflight_d = inflight_q + InfW'(launch) - InfW'(v2n);
    err_d      = err_q;
    if (launch && !can_launch)          err_d = 1'b1;
    if (pair_push && of_full && !pop)   err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsr_q      <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      vsr_q      <= vsr_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mxn_deskew_buffer.sv
// Scoreboard bench for mxn_deskew_buffer with a model two-lane shift pipeline.
module tb_mxn_deskew_buffer;

  localparam int M     = 3;
  localparam int N     = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       launch = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] in0 = '0;
  logic [2:0] in1 = '0;
  logic [2:0] lane0, lane1;
  logic       can_launch, out_valid, err;
  logic [5:0] out_data;
  logic [4:0] level;

  logic [2:0] p0 [N];
  logic [2:0] p1 [2*N];

  int n_chk = 0;
  int n_fail = 0;
  int n_pop = 0;
  logic [5:0] exp_q [$];

  always #5 clk = ~clk;

  // Non-stallable pipeline: lane0 delays in0 by N cycles, lane1 delays in1 by 2N.
  always @(posedge clk) begin
    p0[0] <= in0;
    for (int i = 1; i < N; i++) p0[i] <= p0[i-1];
    p1[0] <= in1;
    for (int i = 1; i < 2*N; i++) p1[i] <= p1[i-1];
  end
  assign lane0 = p0[N-1];
  assign lane1 = p1[2*N-1];

  mxn_deskew_buffer #(
    .M     (M),
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .launch     (launch),
    .lane0      (lane0),
    .lane1      (lane1),
    .can_launch (can_launch),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .err        (err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pair must match the oldest expected pair.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pair: got %0h, expected no pair", out_data);
      end else begin
        chk("pair_order", int'(out_data), int'(exp_q.pop_front()));
      end
      n_pop++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_launch(input logic [2:0] a, input logic [2:0] b, input bit expect_pair);
    launch = 1'b1;
    in0 = a;
    in1 = b;
    if (expect_pair) exp_q.push_back({b, a});
  endtask

  task automatic wait_level(input string name, input int target, input int budget);
    int k;
    k = 0;
    while (int'(level) != target && k < budget) begin
      tick();
      k++;
    end
    chk(name, int'(level), target);
  endtask

  task automatic fill16();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("fill_credit", int'(can_launch), 1);
      do_launch(3'(i), 3'(i * 5 + 1), 1'b1);
      tick();
    end
    launch = 1'b0;
    chk("credit_off_after_16", int'(can_launch), 0);
    wait_level("fill_level16", 16, 30);
    chk("fill_credit_still_off", int'(can_launch), 0);
  endtask

  initial begin
    int p;

    // Reset values
    tick();
    tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_can_launch", int'(can_launch), 1);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    tick();

    // 1: single launch, latency 2N+1
    do_launch(3'h5, 3'h2, 1'b1);
    tick();
    launch = 1'b0;
    repeat (7) tick();
    chk("t1_valid_c8", int'(out_valid), 0);
    tick();
    chk("t1_valid_c9", int'(out_valid), 1);
    chk("t1_data_c9", int'(out_data), 'h15);
    chk("t1_level_c9", int'(level), 1);
    out_ready = 1'b1;
    tick();
    chk("t1_level_after_pop", int'(level), 0);
    chk("t1_valid_after_pop", int'(out_valid), 0);

    // 2: fill with out_ready=0, then drain
    fill16();
    out_ready = 1'b1;
    p = n_pop;
    tick();
    chk("t2_credit_return", int'(can_launch), 1);
    chk("t2_level15", int'(level), 15);
    wait_level("t2_drained", 0, 40);
    chk("t2_drain_count", n_pop - p, 16);

    // 3: 40 back-to-back launches with out_ready=1
    p = n_pop;
    for (int i = 0; i < 40; i++) begin
      chk("t3_credit", int'(can_launch), 1);
      chk("t3_valid", int'(out_valid), (i >= 9) ? 1 : 0);
      do_launch(3'(i), 3'(i * 3 + 2), 1'b1);
      tick();
    end
    launch = 1'b0;
    for (int c = 40; c < 50; c++) begin
      chk("t3_valid_tail", int'(out_valid), (c <= 48) ? 1 : 0);
      tick();
    end
    chk("t3_pair_count", n_pop - p, 40);

    // 4: launch while no credit -> err, pair dropped
    fill16();
    chk("t4_err_before", int'(err), 0);
    chk("t4_no_credit", int'(can_launch), 0);
    do_launch(3'h7, 3'h7, 1'b0);
    tick();
    launch = 1'b0;
    chk("t4_err_set", int'(err), 1);
    repeat (8) tick();
    chk("t4_level_kept", int'(level), 16);
    chk("t4_err_sticky", int'(err), 1);
    chk("t4_queue_size", exp_q.size(), 16);

    // 5: full FIFO, arriving pair coincides with a pop -> pair accepted
    do_launch(3'h6, 3'h1, 1'b1);
    tick();
    launch = 1'b0;
    repeat (7) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_level16", int'(level), 16);
    chk("t5_err_sticky", int'(err), 1);
    out_ready = 1'b1;
    p = n_pop;
    wait_level("t5_drained", 0, 40);
    chk("t5_drain_count", n_pop - p, 16);
    chk("t5_queue_empty", exp_q.size(), 0);

    // 6: reset mid-stream with 3 queued and 5 in flight
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_err_cleared", int'(err), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_launch(3'(i + 1), 3'(7 - i), 1'b1);
      tick();
    end
    launch = 1'b0;
    repeat (3) tick();
    chk("t6_level_pre", int'(level), 3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_level", int'(level), 0);
    chk("t6_rst_credit", int'(can_launch), 1);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("t6_no_stale", int'(out_valid), 0);
      tick();
    end
    out_ready = 1'b1;
    do_launch(3'h3, 3'h4, 1'b1);
    tick();
    launch = 1'b0;
    repeat (7) tick();
    chk("t6_valid_c8", int'(out_valid), 0);
    tick();
    chk("t6_valid_c9", int'(out_valid), 1);
    chk("t6_data_c9", int'(out_data), 'h23);
    tick();
    chk("t6_queue_empty", exp_q.size(), 0);
    chk("t6_level_end", int'(level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
